// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAND,
    ST_PRESSED
  } kp_state_e;

  typedef enum logic [1:0] {
    FR_NONE,
    FR_SINGLE,
    FR_MULTI
  } frame_class_e;

  function automatic int kp_clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Small event queue with a registered read pointer; the head entry is always presented.
// A push into a full queue succeeds only when a pop frees a slot in the same cycle.
module key_fifo
  import keypad_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             overflow_o
);

  localparam int AW = (kp_clog2(DEPTH) > 0) ? kp_clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             pop_ok;
  logic             push_ok;

  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_ok     = pop_i & ~empty_o;
  assign push_ok    = push_i & (~full_o | pop_ok);
  assign overflow_o = push_i & full_o & ~pop_ok;
  assign data_o     = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        wr_ptr_q                <= wr_ptr_q + PTR_ONE;
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Column-scanning keypad front end: synchronizes rows, classifies each frame and
// debounces one key per frame end. IDLE | no key; CAND | counting stable frames; PRESSED | accepted, awaiting release.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS          = 4,
  parameter int COLS          = 4,
  parameter int SCAN_DIV      = 256,
  parameter int DEBOUNCE      = 4,
  parameter int REPEAT_FRAMES = 0,
  parameter int FIFO_DEPTH    = 4,
  localparam int KEY_W        = kp_clog2(ROWS * COLS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ROWS-1:0]  row_in,
  output logic [COLS-1:0]  col_drv,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  input  logic             key_ready,
  output logic             overflow
);

  localparam int SLOT_W = (kp_clog2(SCAN_DIV) > 0) ? kp_clog2(SCAN_DIV) : 1;
  localparam int COL_W  = (kp_clog2(COLS) > 0) ? kp_clog2(COLS) : 1;
  localparam int DB_W   = kp_clog2(DEBOUNCE + 1);
  localparam int REP_W  = (kp_clog2(REPEAT_FRAMES + 1) > 0) ? kp_clog2(REPEAT_FRAMES + 1) : 1;

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE);
  localparam logic [DB_W-1:0]   DB_ONE    = 1;
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_FRAMES);
  localparam logic [REP_W-1:0]  REP_ONE   = 1;

  logic [ROWS-1:0]   row_s1_q, row_s2_q;
  logic [SLOT_W-1:0] slot_q;
  logic [COL_W-1:0]  col_q;
  logic [COLS-1:0]   col_drv_q;
  logic [1:0]        hit_cnt_q;
  logic [KEY_W-1:0]  hit_code_q;

  kp_state_e         state_q, state_d;
  logic [KEY_W-1:0]  cand_q, cand_d;
  logic [DB_W-1:0]   cnt_q, cnt_d;
  logic [DB_W-1:0]   rel_q, rel_d;
  logic [REP_W-1:0]  rep_q, rep_d;
  logic              push;

  logic              sample;
  logic              frame_end;
  logic [1:0]        samp_cnt;
  logic [KEY_W-1:0]  samp_code;
  logic [2:0]        tot_sum;
  logic [1:0]        tot_cnt;
  logic [KEY_W-1:0]  tot_code;
  frame_class_e      fclass;

  logic              fifo_full;
  logic              fifo_empty;

  assign sample    = (slot_q == SLOT_LAST);
  assign frame_end = sample && (col_q == COL_LAST);
  assign col_drv   = col_drv_q;
  assign key_valid = ~fifo_empty;

  // Active-row count saturates at 2: anything beyond one key is simply MULTI.
  always_comb begin
    samp_cnt  = 2'd0;
    samp_code = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (row_s2_q[r]) begin
        if (samp_cnt != 2'd2) samp_cnt = samp_cnt + 2'd1;
        samp_code = KEY_W'(r * COLS + int'(col_q));
      end
    end
    tot_sum  = {1'b0, hit_cnt_q} + {1'b0, samp_cnt};
    tot_cnt  = (tot_sum > 3'd2) ? 2'd2 : tot_sum[1:0];
    tot_code = (samp_cnt != 2'd0) ? samp_code : hit_code_q;
    case (tot_cnt)
      2'd0:    fclass = FR_NONE;
      2'd1:    fclass = FR_SINGLE;
      default: fclass = FR_MULTI;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    rel_d   = rel_q;
    rep_d   = rep_q;
    push    = 1'b0;
    if (frame_end) begin
      case (state_q)
        ST_IDLE: begin
          if (fclass == FR_SINGLE) begin
            cand_d = tot_code;
            if (DEBOUNCE == 1) begin
              push    = 1'b1;
              state_d = ST_PRESSED;
              rep_d   = '0;
              rel_d   = '0;
              cnt_d   = '0;
            end else begin
              cnt_d   = DB_ONE;
              state_d = ST_CAND;
            end
          end
        end
        ST_CAND: begin
          if (fclass == FR_SINGLE) begin
            if (tot_code == cand_q) begin
              if (cnt_q + DB_ONE == DB_LAST) begin
                push    = 1'b1;
                state_d = ST_PRESSED;
                rep_d   = '0;
                rel_d   = '0;
                cnt_d   = '0;
              end else begin
                cnt_d = cnt_q + DB_ONE;
              end
            end else begin
              cand_d = tot_code;
              cnt_d  = DB_ONE;
            end
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
        ST_PRESSED: begin
          if (fclass == FR_NONE) begin
            if (rel_q + DB_ONE == DB_LAST) begin
              state_d = ST_IDLE;
              rel_d   = '0;
              rep_d   = '0;
            end else begin
              rel_d = rel_q + DB_ONE;
            end
          end else begin
            rel_d = '0;
            if (REPEAT_FRAMES > 0 && fclass == FR_SINGLE && tot_code == cand_q) begin
              if (rep_q + REP_ONE == REP_LAST) begin
                push  = 1'b1;
                rep_d = '0;
              end else begin
                rep_d = rep_q + REP_ONE;
              end
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_s1_q   <= '0;
      row_s2_q   <= '0;
      slot_q     <= '0;
      col_q      <= '0;
      col_drv_q  <= COLS'(1);
      hit_cnt_q  <= 2'd0;
      hit_code_q <= '0;
      state_q    <= ST_IDLE;
      cand_q     <= '0;
      cnt_q      <= '0;
      rel_q      <= '0;
      rep_q      <= '0;
    end else begin
      row_s1_q <= row_in;
      row_s2_q <= row_s1_q;
      if (sample) begin
        slot_q <= '0;
        if (col_q == COL_LAST) begin
          col_q     <= '0;
          col_drv_q <= COLS'(1);
          hit_cnt_q <= 2'd0;
        end else begin
          col_q     <= col_q + COL_W'(1);
          col_drv_q <= {col_drv_q[COLS-2:0], 1'b0};
          hit_cnt_q <= tot_cnt;
        end
        hit_code_q <= tot_code;
      end else begin
        slot_q <= slot_q + SLOT_W'(1);
      end
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      rel_q   <= rel_d;
      rep_q   <= rep_d;
    end
  end

  key_fifo #(
    .WIDTH (KEY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (push),
    .data_i     (cand_d),
    .pop_i      (key_valid & key_ready),
    .data_o     (key_code),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .overflow_o (overflow)
  );

  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_keypad_scanner.sv
// Keypad scanner bench: a simulated key matrix, a frame-level reference model and
// an event monitor compare the DUT against directed and random key sequences.
module tb_keypad_scanner;

  localparam int ROWS = 4, COLS = 4, SCAN_DIV = 8, DEBOUNCE = 4;
  localparam int REPEAT_FRAMES = 8, FIFO_DEPTH = 4, KEY_W = 4;
  localparam int FRAME = COLS * SCAN_DIV;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [ROWS-1:0]  row_in;
  logic [COLS-1:0]  col_drv;
  logic [KEY_W-1:0] key_code;
  logic             key_valid;
  logic             key_ready = 1'b0;
  logic             overflow;
  logic [ROWS*COLS-1:0] keys = '0;

  int checks = 0, failures = 0;
  int exp_q[$];
  int mdl_occ = 0, exp_ovf = 0, ovf_seen = 0, got_cnt = 0, got_last = -1;
  bit m_pressed = 0;
  int m_key = -1, m_run = 0, m_quiet = 0, m_rep = 0;

  always #5 clk = ~clk;

  keypad_scanner #(
    .ROWS          (ROWS),
    .COLS          (COLS),
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE      (DEBOUNCE),
    .REPEAT_FRAMES (REPEAT_FRAMES),
    .FIFO_DEPTH    (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .row_in    (row_in),
    .col_drv   (col_drv),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .overflow  (overflow)
  );

  // Key matrix: a pressed key connects its column drive to its row line.
  always_comb begin
    row_in = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (col_drv[c] && keys[r*COLS+c]) row_in[r] = 1'b1;
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (overflow) ovf_seen++;
      if (key_valid && key_ready) begin
        got_cnt++;
        got_last = int'(key_code);
        if (exp_q.size() == 0) check_eq("unexpected_event", int'(key_code), -1);
        else check_eq("event_code", int'(key_code), exp_q.pop_front());
        if (mdl_occ > 0) mdl_occ--;
      end
    end
  end

  task automatic model_emit(input int k);
    if (mdl_occ < FIFO_DEPTH) begin
      exp_q.push_back(k);
      mdl_occ++;
    end else begin
      exp_ovf++;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    mdl_occ = 0;
    m_pressed = 0; m_key = -1; m_run = 0; m_quiet = 0; m_rep = 0;
  endtask

  // One frame of the debounce rules, applied to the set of keys held that frame.
  task automatic model_frame(input logic [ROWS*COLS-1:0] ks);
    int n, k;
    n = $countones(ks);
    k = -1;
    for (int i = 0; i < ROWS*COLS; i++) if (ks[i] && k < 0) k = i;
    if (!m_pressed) begin
      if (n == 1) begin
        if (m_run > 0 && k == m_key) m_run++;
        else begin m_key = k; m_run = 1; end
        if (m_run >= DEBOUNCE) begin
          model_emit(m_key);
          m_pressed = 1; m_rep = 0; m_quiet = 0; m_run = 0;
        end
      end else begin
        m_run = 0;
      end
    end else if (n == 0) begin
      m_quiet++;
      if (m_quiet >= DEBOUNCE) begin m_pressed = 0; m_quiet = 0; end
    end else begin
      m_quiet = 0;
      if (n == 1 && k == m_key && REPEAT_FRAMES > 0) begin
        m_rep++;
        if (m_rep >= REPEAT_FRAMES) begin model_emit(m_key); m_rep = 0; end
      end
    end
  endtask

  // Called #1 after a frame-end edge; returns #1 after the next frame-end edge.
  task automatic run_frame(input logic [ROWS*COLS-1:0] ks);
    int o0, e0;
    o0 = ovf_seen;
    e0 = exp_ovf;
    keys = ks;
    @(posedge clk); #1;
    check_eq("valid_early", int'(key_valid), int'(mdl_occ > 0));
    repeat (FRAME - 1) @(posedge clk);
    #1;
    model_frame(ks);
    check_eq("valid_frame", int'(key_valid), int'(mdl_occ > 0));
    if (mdl_occ > 0) check_eq("head_code", int'(key_code), exp_q[0]);
    check_eq("ovf_frame", ovf_seen - o0, exp_ovf - e0);
  endtask

  task automatic run_frames(input logic [ROWS*COLS-1:0] ks, input int n);
    for (int i = 0; i < n; i++) run_frame(ks);
  endtask

  task automatic press(input int k);
    run_frames(16'(1) << k, DEBOUNCE);
    run_frames('0, DEBOUNCE);
  endtask

  int base, obase;
  logic [ROWS*COLS-1:0] ks;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_col_drv", int'(col_drv), 1);
    check_eq("rst_valid", int'(key_valid), 0);
    check_eq("rst_code", int'(key_code), 0);
    check_eq("rst_overflow", int'(overflow), 0);
    reset = 1'b0;
    key_ready = 1'b1;

    base = got_cnt;
    run_frames(16'(1) << 9, 6);
    run_frames('0, 5);
    check_eq("t1_count", got_cnt - base, 1);
    check_eq("t1_code", got_last, 9);

    base = got_cnt;
    run_frame(16'(1) << 5); run_frame('0);
    run_frame(16'(1) << 5); run_frame('0);
    run_frames(16'(1) << 5, 6);
    run_frames('0, 5);
    check_eq("bounce_count", got_cnt - base, 1);
    check_eq("bounce_code", got_last, 5);

    base = got_cnt;
    run_frames(16'h8001, 10);
    run_frames('0, 2);
    check_eq("multi_count", got_cnt - base, 0);

    base = got_cnt;
    run_frames(16'(1) << 3, 4);
    run_frames((16'(1) << 3) | (16'(1) << 7), 3);
    run_frames('0, 5);
    check_eq("hold_multi_count", got_cnt - base, 1);
    check_eq("hold_multi_code", got_last, 3);

    key_ready = 1'b0;
    base = got_cnt;
    obase = ovf_seen;
    press(1); press(2); press(3); press(4); press(6);
    check_eq("ovf_count", ovf_seen - obase, 1);
    key_ready = 1'b1;
    run_frame('0);
    check_eq("drain_count", got_cnt - base, 4);
    check_eq("drain_last", got_last, 4);

    base = got_cnt;
    run_frames(16'(1) << 12, 20);
    run_frames('0, 5);
    check_eq("repeat_count", got_cnt - base, 3);

    key_ready = 1'b0;
    press(1); press(2);
    run_frames(16'(1) << 8, 2);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_eq("mid_rst_col_drv", int'(col_drv), 1);
    check_eq("mid_rst_valid", int'(key_valid), 0);
    check_eq("mid_rst_code", int'(key_code), 0);
    check_eq("mid_rst_overflow", int'(overflow), 0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    key_ready = 1'b1;
    base = got_cnt;
    run_frames(16'(1) << 8, 4);
    run_frames('0, 5);
    check_eq("post_rst_count", got_cnt - base, 1);
    check_eq("post_rst_code", got_last, 8);

    for (int seg = 0; seg < 40; seg++) begin
      case ($urandom_range(0, 3))
        0:       ks = '0;
        1, 2:    ks = 16'(1) << $urandom_range(0, 15);
        default: ks = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
      endcase
      run_frames(ks, int'($urandom_range(1, 10)));
    end
    run_frames('0, 5);
    check_eq("leftover_events", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
